rgb2ycbcr: RTL

RGB2YCBCR -- requirements
Module: rgb2ycbcr

---
 rtl/rgb2ycbcr.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rgb2ycbcr.sv
// rtl/rgb2ycbcr.sv - RGB to full-range BT.601 YCbCr converter with per-frame Y peak tracker
//
// Purpose: free-running 3-stage pipeline: multiply, sum, scale/clamp. Sync flags
//          travel alongside the data. A two-state tracker latches the largest Y
//          of each completed frame.
// Option : define RGB2YCBCR_ROUND_EN to round half up instead of truncating.
// Ports  : i_sys_clk             - system clock, rising edge
//          i_rst_n               - asynchronous active-low reset
//          i_vs, i_hs            - frame / line sync in
//          i_convert_en          - input pixel valid
//          i_red/green/blue[7:0] - unsigned RGB pixel
//          o_vs, o_hs            - sync delayed 3 cycles
//          o_convert_en          - pixel valid delayed 3 cycles
//          o_y/cb/cr_data[7:0]   - converted pixel, held while not valid
//          o_y_peak[7:0]         - max Y of the last completed frame
//          o_frame_done          - one-cycle pulse when o_y_peak updates
module rgb2ycbcr (
  input  logic       i_sys_clk,
  input  logic       i_rst_n,
  input  logic       i_vs,
  input  logic       i_hs,
  input  logic       i_convert_en,
  input  logic [7:0] i_red,
  input  logic [7:0] i_green,
  input  logic [7:0] i_blue,
  output logic       o_vs,
  output logic       o_hs,
  output logic       o_convert_en,
  output logic [7:0] o_y_data,
  output logic [7:0] o_cb_data,
  output logic [7:0] o_cr_data,
  output logic [7:0] o_y_peak,
  output logic       o_frame_done
);

`ifdef RGB2YCBCR_ROUND_EN
  localparam logic [19:0] RND = 20'd512;
`else
  localparam logic [19:0] RND = 20'd0;
`endif
  localparam logic [19:0] CHROMA_OFS = 20'd131072;  // 128 << 10

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  function automatic logic [17:0] mul(input logic [7:0] a, input logic [9:0] c);
    return 18'(a) * 18'(c);
  endfunction

  // Sums above 255.x (bits 19:18 set) saturate.
  function automatic logic [7:0] sat(input logic [19:0] s);
    return (s[19:18] != 2'b00) ? 8'hFF : s[17:10];
  endfunction

  // Stage 1: coefficient magnitudes; the signs are applied in stage 2.
  logic [17:0] p_yr, p_yg, p_yb, p_cbr, p_cbg, p_cbb, p_crr, p_crg, p_crb;
  logic [19:0] y_sum, cb_sum, cr_sum;
  logic        vs_s1, vs_s2, hs_s1, hs_s2, en_s1, en_s2;
  logic        low_s1, low_s2, low_s3;
  logic [7:0]  y_nxt, cb_nxt, cr_nxt;
  state_t      state_q, state_d;
  logic [7:0]  run_peak_q, run_peak_d, y_peak_d, pix_peak;
  logic        done_d;

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p_yr  <= '0; p_yg  <= '0; p_yb  <= '0;
      p_cbr <= '0; p_cbg <= '0; p_cbb <= '0;
      p_crr <= '0; p_crg <= '0; p_crb <= '0;
      y_sum <= '0; cb_sum <= '0; cr_sum <= '0;
    end else begin
      p_yr  <= mul(i_red, 10'd306);
      p_yg  <= mul(i_green, 10'd601);
      p_yb  <= mul(i_blue, 10'd117);
      p_cbr <= mul(i_red, 10'd173);
      p_cbg <= mul(i_green, 10'd339);
      p_cbb <= mul(i_blue, 10'd512);
      p_crr <= mul(i_red, 10'd512);
      p_crg <= mul(i_green, 10'd429);
      p_crb <= mul(i_blue, 10'd83);
      // Chroma sums bottom out at 512, so unsigned wrap-free subtraction is safe.
      y_sum  <= 20'(p_yr) + 20'(p_yg) + 20'(p_yb) + RND;
      cb_sum <= CHROMA_OFS + 20'(p_cbb) - 20'(p_cbr) - 20'(p_cbg) + RND;
      cr_sum <= CHROMA_OFS + 20'(p_crr) - 20'(p_crg) - 20'(p_crb) + RND;
    end
  end

  assign y_nxt  = sat(y_sum);
  assign cb_nxt = sat(cb_sum);
  assign cr_nxt = sat(cr_sum);

  // Sync/valid delay line. low_sN records that a genuine low vs has entered the
  // pipeline: after reset the vs taps read 0 whatever the input is, so a frame
  // in progress across reset would otherwise look like a fresh rising edge.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vs_s1 <= 1'b0; vs_s2 <= 1'b0; o_vs <= 1'b0;
      hs_s1 <= 1'b0; hs_s2 <= 1'b0; o_hs <= 1'b0;
      en_s1 <= 1'b0; en_s2 <= 1'b0; o_convert_en <= 1'b0;
      low_s1 <= 1'b0; low_s2 <= 1'b0; low_s3 <= 1'b0;
      o_y_data  <= 8'd0;
      o_cb_data <= 8'd128;
      o_cr_data <= 8'd128;
    end else begin
      vs_s1 <= i_vs;         vs_s2 <= vs_s1; o_vs <= vs_s2;
      hs_s1 <= i_hs;         hs_s2 <= hs_s1; o_hs <= hs_s2;
      en_s1 <= i_convert_en; en_s2 <= en_s1; o_convert_en <= en_s2;
      low_s1 <= low_s1 | ~i_vs;
      low_s2 <= low_s1;
      low_s3 <= low_s2;
      if (en_s2) begin
        o_y_data  <= y_nxt;
        o_cb_data <= cb_nxt;
        o_cr_data <= cr_nxt;
      end
    end
  end

  // Tracker sees the values being loaded into the outputs, so the frame-end
  // pixel lands in the peak and o_frame_done rises together with o_vs falling.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      run_peak_q   <= 8'd0;
      o_y_peak     <= 8'd0;
      o_frame_done <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_peak_q   <= run_peak_d;
      o_y_peak     <= y_peak_d;
      o_frame_done <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    run_peak_d = run_peak_q;
    y_peak_d   = o_y_peak;
    done_d     = 1'b0;
    pix_peak   = (en_s2 && (y_nxt > run_peak_q)) ? y_nxt : run_peak_q;
    case (state_q)
      ST_IDLE: begin
        if (vs_s2 && !o_vs && low_s3) begin
          state_d    = ST_ACTIVE;
          run_peak_d = 8'd0;
        end
      end
      ST_ACTIVE: begin
        run_peak_d = pix_peak;
        if (!vs_s2 && o_vs) begin
          y_peak_d = pix_peak;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
